// File: rtl/sump_pkg.sv
// Shared opcodes, FSM state type and payload geometry for the SUMP command decoder.
package sump_pkg;

  localparam logic [7:0] OP_RESET = 8'h00;
  localparam logic [7:0] OP_ARM   = 8'h01;
  localparam logic [7:0] OP_QMETA = 8'h02;
  localparam logic [7:0] OP_QID   = 8'h04;
  localparam logic [7:0] OP_DIV   = 8'h80;
  localparam logic [7:0] OP_RDDLY = 8'h81;
  localparam logic [7:0] OP_TRIG  = 8'hC1;

  localparam int PAYLOAD_BYTES = 4;

  typedef enum logic {IDLE, PAYLOAD} sump_dec_state_t;

endpackage

// File: rtl/sump_cmd_decoder.sv
// Decodes SUMP host commands from the UART byte stream into command strobes
// and sampler/trigger configuration registers.
module sump_cmd_decoder
  import sump_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic                    system_clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    capture_busy,
  output logic                    cmd_reset,
  output logic                    cmd_arm,
  output logic                    cmd_query_meta,
  output logic                    cmd_query_id,
  output logic [23:0]             cfg_divider,
  output logic [15:0]             cfg_read_count,
  output logic [15:0]             cfg_delay_count,
  output logic [SAMPLE_WIDTH-1:0] cfg_trig_rise,
  output logic [SAMPLE_WIDTH-1:0] cfg_trig_fall,
  output logic                    cfg_update,
  output logic                    cmd_unknown
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(PAYLOAD_BYTES);
  localparam int PW = 8 * (PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(PAYLOAD_BYTES - 1);

  sump_dec_state_t   state_reg, state_next;
  logic [7:0]        opcode_reg, opcode_next;
  logic [PW-1:0]     payload_reg, payload_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [TW-1:0]     timeout_reg, timeout_next;

  logic cmd_reset_reg, cmd_reset_next;
  logic cmd_arm_reg, cmd_arm_next;
  logic cmd_query_meta_reg, cmd_query_meta_next;
  logic cmd_query_id_reg, cmd_query_id_next;
  logic cfg_update_reg, cfg_update_next;
  logic cmd_unknown_reg, cmd_unknown_next;

  logic [23:0]             cfg_divider_reg, cfg_divider_next;
  logic [15:0]             cfg_read_count_reg, cfg_read_count_next;
  logic [15:0]             cfg_delay_count_reg, cfg_delay_count_next;
  logic [SAMPLE_WIDTH-1:0] cfg_trig_rise_reg, cfg_trig_rise_next;
  logic [SAMPLE_WIDTH-1:0] cfg_trig_fall_reg, cfg_trig_fall_next;

  logic [31:0] word;

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_reg           <= IDLE;
      opcode_reg          <= '0;
      payload_reg         <= '0;
      idx_reg             <= '0;
      timeout_reg         <= '0;
      cmd_reset_reg       <= 1'b0;
      cmd_arm_reg         <= 1'b0;
      cmd_query_meta_reg  <= 1'b0;
      cmd_query_id_reg    <= 1'b0;
      cfg_update_reg      <= 1'b0;
      cmd_unknown_reg     <= 1'b0;
      cfg_divider_reg     <= '0;
      cfg_read_count_reg  <= '0;
      cfg_delay_count_reg <= '0;
      cfg_trig_rise_reg   <= '0;
      cfg_trig_fall_reg   <= '0;
    end else begin
      state_reg           <= state_next;
      opcode_reg          <= opcode_next;
      payload_reg         <= payload_next;
      idx_reg             <= idx_next;
      timeout_reg         <= timeout_next;
      cmd_reset_reg       <= cmd_reset_next;
      cmd_arm_reg         <= cmd_arm_next;
      cmd_query_meta_reg  <= cmd_query_meta_next;
      cmd_query_id_reg    <= cmd_query_id_next;
      cfg_update_reg      <= cfg_update_next;
      cmd_unknown_reg     <= cmd_unknown_next;
      cfg_divider_reg     <= cfg_divider_next;
      cfg_read_count_reg  <= cfg_read_count_next;
      cfg_delay_count_reg <= cfg_delay_count_next;
      cfg_trig_rise_reg   <= cfg_trig_rise_next;
      cfg_trig_fall_reg   <= cfg_trig_fall_next;
    end
  end

  always_comb begin
    state_next           = state_reg;
    opcode_next          = opcode_reg;
    payload_next         = payload_reg;
    idx_next             = idx_reg;
    timeout_next         = timeout_reg;
    cmd_reset_next       = 1'b0;
    cmd_arm_next         = 1'b0;
    cmd_query_meta_next  = 1'b0;
    cmd_query_id_next    = 1'b0;
    cfg_update_next      = 1'b0;
    cmd_unknown_next     = 1'b0;
    cfg_divider_next     = cfg_divider_reg;
    cfg_read_count_next  = cfg_read_count_reg;
    cfg_delay_count_next = cfg_delay_count_reg;
    cfg_trig_rise_next   = cfg_trig_rise_reg;
    cfg_trig_fall_next   = cfg_trig_fall_reg;
    word                 = '0;

    // Idle-gap counter: only meaningful while a long command is half received.
    if (rx_valid) begin
      timeout_next = '0;
    end else if (state_reg == PAYLOAD) begin
      if (timeout_reg != TIMEOUT_MAX) timeout_next = timeout_reg + TW'(1);
    end else begin
      timeout_next = '0;
    end

    case (state_reg)
      IDLE: begin
        if (rx_valid) begin
          if (!rx_data[7]) begin
            case (rx_data)
              OP_RESET: cmd_reset_next      = 1'b1;
              OP_ARM:   cmd_arm_next        = !capture_busy;
              OP_QMETA: cmd_query_meta_next = 1'b1;
              OP_QID:   cmd_query_id_next   = 1'b1;
              default:  cmd_unknown_next    = 1'b1;
            endcase
          end else begin
            opcode_next = rx_data;
            idx_next    = '0;
            state_next  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          if (idx_reg == IDX_LAST) begin
            // Final byte is used straight off the wire so the update lands one cycle later.
            word       = {payload_reg, rx_data};
            state_next = IDLE;
            case (opcode_reg)
              OP_DIV: begin
                cfg_divider_next = word[23:0];
                cfg_update_next  = 1'b1;
              end
              OP_RDDLY: begin
                cfg_read_count_next  = word[31:16];
                cfg_delay_count_next = word[15:0];
                cfg_update_next      = 1'b1;
              end
              OP_TRIG: begin
                cfg_trig_fall_next = word[8 +: SAMPLE_WIDTH];
                cfg_trig_rise_next = word[0 +: SAMPLE_WIDTH];
                cfg_update_next    = 1'b1;
              end
              default: cmd_unknown_next = 1'b1;
            endcase
          end else begin
            payload_next = {payload_reg[PW-9:0], rx_data};
            idx_next     = idx_reg + IW'(1);
          end
        end else if (timeout_reg == TIMEOUT_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_reset       = cmd_reset_reg;
  assign cmd_arm         = cmd_arm_reg;
  assign cmd_query_meta  = cmd_query_meta_reg;
  assign cmd_query_id    = cmd_query_id_reg;
  assign cfg_update      = cfg_update_reg;
  assign cmd_unknown     = cmd_unknown_reg;
  assign cfg_divider     = cfg_divider_reg;
  assign cfg_read_count  = cfg_read_count_reg;
  assign cfg_delay_count = cfg_delay_count_reg;
  assign cfg_trig_rise   = cfg_trig_rise_reg;
  assign cfg_trig_fall   = cfg_trig_fall_reg;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Scoreboard bench for sump_cmd_decoder: a byte-level command model predicts
// every strobe, its cycle and the configuration it leaves behind.
module tb_sump_cmd_decoder;

  localparam int SW = 8;
  localparam int T  = 20;

  logic          system_clock = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          capture_busy;
  logic          cmd_reset, cmd_arm, cmd_query_meta, cmd_query_id;
  logic [23:0]   cfg_divider;
  logic [15:0]   cfg_read_count, cfg_delay_count;
  logic [SW-1:0] cfg_trig_rise, cfg_trig_fall;
  logic          cfg_update, cmd_unknown;

  sump_cmd_decoder #(.SAMPLE_WIDTH(SW), .TIMEOUT_CYCLES(T)) dut (
    .system_clock   (system_clock),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .capture_busy   (capture_busy),
    .cmd_reset      (cmd_reset),
    .cmd_arm        (cmd_arm),
    .cmd_query_meta (cmd_query_meta),
    .cmd_query_id   (cmd_query_id),
    .cfg_divider    (cfg_divider),
    .cfg_read_count (cfg_read_count),
    .cfg_delay_count(cfg_delay_count),
    .cfg_trig_rise  (cfg_trig_rise),
    .cfg_trig_fall  (cfg_trig_fall),
    .cfg_update     (cfg_update),
    .cmd_unknown    (cmd_unknown)
  );

  always #5 system_clock = ~system_clock;

  int cyc = 0;
  always @(posedge system_clock) cyc <= cyc + 1;

  // strobe vector order: reset, arm, qmeta, qid, update, unknown
  typedef struct {
    int            cyc;
    logic [5:0]    stb;
    logic [23:0]   div;
    logic [15:0]   rc;
    logic [15:0]   dc;
    logic [SW-1:0] rise;
    logic [SW-1:0] fall;
  } exp_t;

  exp_t expq[$];
  int total = 0;
  int bad = 0;
  bit mon_en = 0;

  // model-side configuration (advances when a byte is issued)
  logic [23:0]   m_div = '0;
  logic [15:0]   m_rc = '0, m_dc = '0;
  logic [SW-1:0] m_rise = '0, m_fall = '0;
  // monitor-side configuration (advances when the DUT shows the update)
  logic [23:0]   h_div = '0;
  logic [15:0]   h_rc = '0, h_dc = '0;
  logic [SW-1:0] h_rise = '0, h_fall = '0;

  bit         pl_active = 0;
  logic [7:0] pl_op = '0;
  logic [7:0] pl_bytes[$];
  int         gap = 0;

  function automatic void model(input logic [7:0] b, input logic busy);
    logic [5:0]  stb;
    logic [31:0] w;
    exp_t        e;
    stb = '0;
    if (pl_active && gap >= T) pl_active = 0;
    if (!pl_active) begin
      if (b[7]) begin
        pl_active = 1;
        pl_op = b;
        pl_bytes.delete();
        return;
      end
      case (b)
        8'h00:   stb = 6'b100000;
        8'h01:   stb = busy ? 6'b000000 : 6'b010000;
        8'h02:   stb = 6'b001000;
        8'h04:   stb = 6'b000100;
        default: stb = 6'b000001;
      endcase
    end else begin
      pl_bytes.push_back(b);
      if (pl_bytes.size() < 4) return;
      w = {pl_bytes[0], pl_bytes[1], pl_bytes[2], pl_bytes[3]};
      pl_active = 0;
      case (pl_op)
        8'h80: begin m_div = w[23:0]; stb = 6'b000010; end
        8'h81: begin m_rc = w[31:16]; m_dc = w[15:0]; stb = 6'b000010; end
        8'hC1: begin m_fall = w[15:8]; m_rise = w[7:0]; stb = 6'b000010; end
        default: stb = 6'b000001;
      endcase
    end
    if (stb != 0) begin
      e.cyc = cyc + 1; e.stb = stb; e.div = m_div; e.rc = m_rc; e.dc = m_dc;
      e.rise = m_rise; e.fall = m_fall;
      expq.push_back(e);
    end
  endfunction

  task automatic send(input logic [7:0] b, input logic busy);
    @(negedge system_clock);
    rx_valid = 1'b1;
    rx_data = b;
    capture_busy = busy;
    model(b, busy);
    gap = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge system_clock);
      rx_valid = 1'b0;
      gap++;
    end
  endtask

  task automatic send_long(input logic [7:0] op, input logic [31:0] w);
    send(op, 1'b0);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8], 1'b0);
  endtask

  always @(negedge system_clock) begin
    logic [5:0] s;
    exp_t e;
    if (mon_en) begin
      s = {cmd_reset, cmd_arm, cmd_query_meta, cmd_query_id, cfg_update, cmd_unknown};
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        e = expq.pop_front();
        total++; bad++;
        $display("FAIL missing_strobe cyc=%0d got=none want stb=%b", e.cyc, e.stb);
        h_div = e.div; h_rc = e.rc; h_dc = e.dc; h_rise = e.rise; h_fall = e.fall;
      end
      total++;
      if (s != 0) begin
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe cyc=%0d got stb=%b want none", cyc, s);
        end else begin
          e = expq.pop_front();
          if (e.cyc != cyc || e.stb != s || e.div != cfg_divider || e.rc != cfg_read_count ||
              e.dc != cfg_delay_count || e.rise != cfg_trig_rise || e.fall != cfg_trig_fall) begin
            bad++;
            $display("FAIL event cyc=%0d/%0d stb=%b/%b div=%h/%h rc=%h/%h dc=%h/%h rise=%h/%h fall=%h/%h (got/want)",
                     cyc, e.cyc, s, e.stb, cfg_divider, e.div, cfg_read_count, e.rc,
                     cfg_delay_count, e.dc, cfg_trig_rise, e.rise, cfg_trig_fall, e.fall);
          end else begin
            $display("event cyc=%0d stb=%b div=%h rc=%h dc=%h rise=%h fall=%h",
                     cyc, s, cfg_divider, cfg_read_count, cfg_delay_count, cfg_trig_rise, cfg_trig_fall);
          end
          h_div = e.div; h_rc = e.rc; h_dc = e.dc; h_rise = e.rise; h_fall = e.fall;
        end
      end else if (h_div != cfg_divider || h_rc != cfg_read_count || h_dc != cfg_delay_count ||
                   h_rise != cfg_trig_rise || h_fall != cfg_trig_fall) begin
        bad++;
        $display("FAIL cfg_hold cyc=%0d got div=%h rc=%h dc=%h rise=%h fall=%h want div=%h rc=%h dc=%h rise=%h fall=%h",
                 cyc, cfg_divider, cfg_read_count, cfg_delay_count, cfg_trig_rise, cfg_trig_fall,
                 h_div, h_rc, h_dc, h_rise, h_fall);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r;
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h00;
    capture_busy = 1'b0;
    repeat (3) begin
      @(negedge system_clock);
      total++;
      if ({cmd_reset, cmd_arm, cmd_query_meta, cmd_query_id, cfg_update, cmd_unknown,
           cfg_divider, cfg_read_count, cfg_delay_count, cfg_trig_rise, cfg_trig_fall} != '0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got strobes=%b div=%h rc=%h dc=%h want all zero", cyc,
                 {cmd_reset, cmd_arm, cmd_query_meta, cmd_query_id, cfg_update, cmd_unknown},
                 cfg_divider, cfg_read_count, cfg_delay_count);
      end
    end
    @(negedge system_clock);
    reset = 1'b0;
    rx_valid = 1'b0;
    mon_en = 1;
    idle(2);

    // directed sequences
    send_long(8'h80, 32'h0000_01F3); idle(2);
    send_long(8'h81, 32'h0018_0018); idle(1);
    send_long(8'hC1, 32'h0000_0001); idle(1);
    repeat (5) send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'h01, 1'b1);
    idle(2);
    send(8'h80, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    idle(T);
    send(8'h04, 1'b0); idle(2);
    send(8'h80, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    idle(T - 1);
    send(8'h00, 1'b0); send(8'h05, 1'b0); idle(2);
    send(8'h02, 1'b0); send(8'h04, 1'b0);
    send_long(8'h9F, 32'hAABB_CCDD); idle(1);
    send(8'h11, 1'b0); send(8'h13, 1'b0); idle(2);

    // randomized traffic
    repeat (200) begin
      if ($urandom_range(0, 9) < 5) begin
        r = $urandom_range(0, 4);
        case (r)
          0: b = 8'h00;
          1: b = 8'h01;
          2: b = 8'h02;
          3: b = 8'h04;
          default: b = {1'b0, 7'($urandom)};
        endcase
        send(b, 1'($urandom_range(0, 1)));
        idle($urandom_range(0, 2));
      end else begin
        r = $urandom_range(0, 3);
        case (r)
          0: b = 8'h80;
          1: b = 8'h81;
          2: b = 8'hC1;
          default: b = {1'b1, 7'($urandom)};
        endcase
        send(b, 1'b0);
        for (int i = 0; i < 4; i++) begin
          r = $urandom_range(0, 19);
          if (r == 0) idle(T);
          else if (r == 1) idle(T - 1);
          else idle($urandom_range(0, 2));
          send(8'($urandom), 1'($urandom_range(0, 1)));
        end
        idle($urandom_range(0, 2));
      end
    end

    idle(T + 4);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
